// File: rtl/arb_onehot4.sv
// Four-way request arbiter with a registered one-hot grant, hold timer and round-robin pointer.
// Build option: define FIXED_PRIO_EN for fixed priority r0 > r1 > r2 > r3 (no pointer state).
module arb_onehot4 #(
  parameter int unsigned TMO_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  input  logic done,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic busy,
  output logic tmo
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] TmoLast = 8'(TMO_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] g_q, g_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [3:0] req;
  logic [3:0] pick;
  logic       own_req;
  logic       expired;
  logic       release_now;

  assign req = {r3, r2, r1, r0};

`ifdef FIXED_PRIO_EN
  always_comb begin
    pick = 4'b0000;
    if      (req[0]) pick = 4'b0001;
    else if (req[1]) pick = 4'b0010;
    else if (req[2]) pick = 4'b0100;
    else if (req[3]) pick = 4'b1000;
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gidx;

  // Walk from the pointer itself (farthest) towards ptr+1 (nearest) so the nearest request wins.
  always_comb begin
    logic [1:0] idx;
    pick = 4'b0000;
    idx  = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        pick      = 4'b0000;
        pick[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (g_q)
      4'b0001: gidx = 2'd0;
      4'b0010: gidx = 2'd1;
      4'b0100: gidx = 2'd2;
      4'b1000: gidx = 2'd3;
      default: gidx = 2'd0;
    endcase
  end
`endif

  assign own_req     = |(req & g_q);
  assign expired     = (cnt_q == TmoLast);
  assign release_now = done || !own_req || expired;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`ifndef FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          g_d     = pick;
          cnt_d   = 8'd0;
        end
      end
      StGrant: begin
        if (release_now) begin
          state_d = StIdle;
          g_d     = 4'b0000;
          // Only a pure timer expiry is flagged; done or a dropped request win.
          tmo_d   = expired && !done && own_req;
`ifndef FIXED_PRIO_EN
          ptr_d   = gidx;
`endif
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        g_d     = 4'b0000;
      end
    endcase
    busy_d = |g_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= 4'b0000;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifndef FIXED_PRIO_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
`ifndef FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign g0   = g_q[0];
  assign g1   = g_q[1];
  assign g2   = g_q[2];
  assign g3   = g_q[3];
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_arb_onehot4.sv
// Directed bench for arb_onehot4: expected outputs are queued per stimulus cycle and
// popped for comparison after the clock edge.
module tb_arb_onehot4;

  logic clk = 1'b0;
  logic rst;
  logic r0, r1, r2, r3, done;
  logic g0, g1, g2, g3, busy, tmo;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];

  always #5 clk = ~clk;

  arb_onehot4 #(.TMO_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .r0   (r0),
    .r1   (r1),
    .r2   (r2),
    .r3   (r3),
    .done (done),
    .g0   (g0),
    .g1   (g1),
    .g2   (g2),
    .g3   (g3),
    .busy (busy),
    .tmo  (tmo)
  );

  // Drive one cycle, queue what must be visible after the edge, then pop and compare.
  task automatic cyc(input string tag, input logic rs, input logic [3:0] r, input logic d,
                     input logic [3:0] eg, input logic et);
    exp_t       e;
    exp_t       got;
    string      t;
    logic [3:0] gv;
    rst  = rs;
    {r3, r2, r1, r0} = r;
    done = d;
    sbq.push_back('{g: eg, busy: |eg, tmo: et});
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    e   = sbq.pop_front();
    t   = tagq.pop_front();
    gv  = {g3, g2, g1, g0};
    got = '{g: gv, busy: busy, tmo: tmo};
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s got g=%b busy=%b tmo=%b exp g=%b busy=%b tmo=%b",
             t, got.g, got.busy, got.tmo, e.g, e.busy, e.tmo);
    end
    checks++;
    assert (($countones(gv) <= 1) && (busy === |gv)) else begin
      errors++;
      $error("FAIL %s_invariant got g=%b busy=%b exp onehot0 with busy=|g", t, gv, busy);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1;
    {r3, r2, r1, r0} = 4'b0000;
    done = 1'b0;

    // Reset with requests present: nothing granted.
    cyc("reset0", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    cyc("reset1", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);

    // All requesting, done pulsed each grant: rotation with one idle cycle between grants.
    for (int i = 0; i < 5; i++) begin
`ifdef FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (i % 4);
`endif
      cyc($sformatf("rr_grant%0d", i), 1'b0, 4'b1111, 1'b0, exp_g, 1'b0);
      cyc($sformatf("rr_rel%0d", i), 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0);
    end
    cyc("quiet", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Lone r2 held: eight grant cycles, timeout pulse, then re-grant.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("tmo_hold%0d", i), 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("tmo_pulse", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1);
    cyc("tmo_regrant", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("tmo_done", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // done on the expiry cycle is a normal release.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("exp_hold%0d", i), 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("exp_done", 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0);
    cyc("exp_after", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // g1 granted, r3 ignored while held, r1 drops: release, idle, then g3.
    cyc("drop_g1", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc("drop_hold", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b0);
    cyc("drop_rel", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
    cyc("drop_g3", 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0);
    cyc("drop_done", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Move the pointer off its reset value, then abort a g2 grant with reset.
    cyc("pre_g0", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    cyc("pre_rel", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc("abort_g2", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("abort_hold", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc("abort_rst", 1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0);
    cyc("abort_rst2", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
    cyc("post_rst_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
    cyc("post_rst_rel", 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0);
`ifdef FIXED_PRIO_EN
    cyc("post_rst_next", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0);
`else
    cyc("post_rst_next", 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0);
`endif
    cyc("end_rel", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_onehot4.md
ARB_ONEHOT4 -- requirements
Module: arb_onehot4

Interface
REQ-001 Parameter TMO_CYCLES, default 8, max cycles a grant is held without release; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 r0, r1, r2, r3  input  1 each  request lines; any combination may be high.
REQ-005 done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 g0, g1, g2, g3  output  1 each  registered grant vector; always all-zero or exactly one-hot; drives the 4-to-2 encoder inputs.
REQ-007 busy  output  1  high whenever any grant line is high.
REQ-008 tmo  output  1  one-cycle pulse on a timeout release.

Function
REQ-009 Two-state FSM: IDLE (g = 0000) and GRANT (one g high); all outputs registered.
REQ-010 IDLE: if any r is high at a clk edge, the FSM enters GRANT and the chosen g is high after that same edge; no request keeps it in IDLE.
REQ-011 Round-robin selection: search starts at index ptr+1 mod 4 and wraps; the first high request wins.
REQ-012 ptr is 2 bits and is loaded with the granted index on every release.
REQ-013 GRANT holds the same g while the grantee's r stays high, done is low, and the timer has not expired.
REQ-014 Release occurs at the edge where done=1 OR the grantee's r=0 OR cnt == TMO_CYCLES-1; the FSM returns to IDLE, and g=0000 and busy=0 for at least one cycle.
REQ-015 Requests other than the grantee's are ignored in GRANT; no preemption.
REQ-016 cnt is 8 bits, cleared on entry to GRANT, and increments each GRANT cycle; it saturates and never wraps.
REQ-017 tmo=1 for exactly the one cycle following a release caused only by the timer; if done=1 on the expiry cycle, the release counts as normal (tmo=0).
REQ-018 A grantee whose r stays high after release is eligible again, but only after the other requesters under round-robin.
REQ-019 busy == (g0|g1|g2|g3) in every cycle.

Reset
REQ-020 rst=1 at a clk edge forces: state IDLE, g=0000, busy=0, tmo=0, cnt=0, ptr=3 (r0 has first priority after reset).
REQ-021 Reset during GRANT drops the grant after that edge, with no tmo pulse and no ptr update from the aborted grant.
REQ-022 Requests sampled while rst=1 are ignored; arbitration starts at the first edge with rst=0.

Configuration
REQ-023 Macro FIXED_PRIO_EN defined: selection is fixed priority r0>r1>r2>r3, ptr is not implemented, and REQ-011/012/018 do not apply.
REQ-024 FIXED_PRIO_EN undefined: round-robin per REQ-011; all other behaviour is identical in both builds.

Verification
REQ-025 After reset, r=1111 held and done pulsed each grant -> grants g0, g1, g2, g3, g0 in order, each separated by one g=0000 cycle.
REQ-026 Only r2 high, done never asserted, TMO_CYCLES=8 -> g2 high for 8 cycles, then g=0000 with tmo=1 for 1 cycle, then g2 again.
REQ-027 Grant on g1, r1 dropped on cycle 3 with r3 high -> g1 releases at that edge, one idle cycle, then g3; tmo stays 0.
REQ-028 rst asserted mid-GRANT on g2 -> next cycle g=0000, busy=0, tmo=0; after release, r=1111 grants g0 first.
REQ-029 FIXED_PRIO_EN build, r=1111 with done pulsed -> g0 is granted every time.
REQ-030 All cycles in every test: the grant vector is never more than one-hot, and busy matches the OR of g.
